// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Instruction fetch bus between the fetch sequencer (master) and the
// instruction memory / bus bridge (slave).
//
// Signals:
//   iadr_o  [63:0]  fetch address, driven by the master
//   istb_o          fetch request strobe, driven by the master
//   iack_i          fetch acknowledge, driven by the slave; idat_i is valid
//                   in the same cycle
//   idat_i  [31:0]  fetched instruction word, driven by the slave
//
// The _o/_i suffixes are seen from the sequencer's side, so the names match
// the sequencer's own port list.
// ----------------------------------------------------------------------------
interface fetch_sequencer_if;
  logic [63:0] iadr_o;
  logic        istb_o;
  logic        iack_i;
  logic [31:0] idat_i;

  modport master (
    output iadr_o,
    output istb_o,
    input  iack_i,
    input  idat_i
  );

  modport slave (
    input  iadr_o,
    input  istb_o,
    output iack_i,
    output idat_i
  );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch / microcycle sequencer. Fetches one 32-bit instruction
// word at a time over the fetch bus, then steps the decoders through
// microcycle states 0..3. State 3 completes the instruction and either
// increments the PC by 4 or loads a branch/jump target. Illegal
// instructions, out-of-range decoder states and misaligned targets raise a
// one-cycle trap that records the cause and the faulting PC and redirects
// fetch to TRAP_PC.
//
// Parameters:
//   RESET_PC       PC loaded by reset
//   TRAP_PC        PC loaded on any trap
//
// Ports:
//   clk_i          clock, all state changes on its rising edge
//   reset_i        synchronous active-high reset
//   ibus           fetch bus (master modport): iadr_o, istb_o, iack_i, idat_i
//   ir_o    [31:0] instruction register, to the decoders' ir_i
//   cstate_o [2:0] current microcycle, to the decoders' cstate_i
//                  (7 outside EXEC so no decoder term is active)
//   nstate_i [2:0] next microcycle, OR of all decoder nstate outputs
//   defined_i      OR of all decoder defined outputs
//   pc_load_i      at completion, load PC from pc_dat_i instead of PC+4
//   pc_dat_i [63:0] branch/jump target
//   pc_o    [63:0] current instruction address
//   trap_o         one-cycle trap pulse
//   trap_cause_o [1:0] 0 illegal instruction, 1 misaligned target,
//                  2 fetch timeout
//   epc_o   [63:0] PC of the instruction that trapped
//
// Build option:
//   FETCH_TIMEOUT_EN  when defined, a fetch that is not acknowledged within
//                     256 FETCH cycles traps with cause 2. When undefined,
//                     FETCH waits indefinitely and no counter exists.
// ----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter logic [63:0] TRAP_PC  = 64'h0000_0000_0000_0100
) (
  input  logic               clk_i,
  input  logic               reset_i,
  fetch_sequencer_if.master  ibus,
  output logic [31:0]        ir_o,
  output logic [2:0]         cstate_o,
  input  logic [2:0]         nstate_i,
  input  logic               defined_i,
  input  logic               pc_load_i,
  input  logic [63:0]        pc_dat_i,
  output logic [63:0]        pc_o,
  output logic               trap_o,
  output logic [1:0]         trap_cause_o,
  output logic [63:0]        epc_o
);

  // Value of the instruction register after reset: addi x0,x0,0 (a NOP).
  localparam logic [31:0] IR_RESET = 32'h0000_0013;

  // cstate value presented whenever the decoders must be idle.
  localparam logic [2:0] CSTATE_IDLE = 3'd7;

  localparam logic [1:0] CAUSE_ILLEGAL    = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'd2;
`endif

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [2:0]  cstate_reg, cstate_next;
  logic [1:0]  cause_reg, cause_next;
  logic [63:0] epc_reg, epc_next;

  logic        istb;
  logic        trap;
  logic [2:0]  cstate_out;

`ifdef FETCH_TIMEOUT_EN
  // Counts unacknowledged FETCH cycles; holds 0 outside FETCH so it is
  // already clear on every entry to FETCH.
  logic [7:0]  tmo_reg, tmo_next;
  logic        tmo_expired;

  assign tmo_expired = (tmo_reg == 8'hFF);

  always_comb begin
    tmo_next = 8'd0;
    if (state_reg == ST_FETCH && !ibus.iack_i) begin
      tmo_next = tmo_reg + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_reg <= 8'd0;
    end else begin
      tmo_reg <= tmo_next;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg  <= ST_FETCH;
      pc_reg     <= RESET_PC;
      ir_reg     <= IR_RESET;
      cstate_reg <= CSTATE_IDLE;
      cause_reg  <= 2'd0;
      epc_reg    <= 64'd0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      ir_reg     <= ir_next;
      cstate_reg <= cstate_next;
      cause_reg  <= cause_next;
      epc_reg    <= epc_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    ir_next     = ir_reg;
    cstate_next = cstate_reg;
    cause_next  = cause_reg;
    epc_next    = epc_reg;
    istb        = 1'b0;
    trap        = 1'b0;
    cstate_out  = CSTATE_IDLE;

    case (state_reg)
      ST_FETCH: begin
        istb = 1'b1;
        if (ibus.iack_i) begin
          // An ack always wins, including on the last timeout cycle.
          ir_next     = ibus.idat_i;
          cstate_next = 3'd0;
          state_next  = ST_EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_expired) begin
          cause_next = CAUSE_TIMEOUT;
          epc_next   = pc_reg;
          state_next = ST_TRAP;
        end
`endif
      end

      ST_EXEC: begin
        cstate_out = cstate_reg;
        if (cstate_reg == 3'd3) begin
          // Completion cycle: decoders have settled pc_load_i/pc_dat_i.
          if (!pc_load_i) begin
            pc_next    = pc_reg + 64'd4;
            state_next = ST_FETCH;
          end else if (pc_dat_i[1:0] == 2'b00) begin
            pc_next    = pc_dat_i;
            state_next = ST_FETCH;
          end else begin
            cause_next = CAUSE_MISALIGNED;
            epc_next   = pc_reg;
            state_next = ST_TRAP;
          end
        end else if ((cstate_reg == 3'd0 && !defined_i) || nstate_i[2]) begin
          // No decoder claimed the opcode, or the decoders asked for a
          // microcycle beyond 3: both are illegal instructions. The
          // instruction register is left holding the offending word.
          cause_next = CAUSE_ILLEGAL;
          epc_next   = pc_reg;
          state_next = ST_TRAP;
        end else begin
          cstate_next = nstate_i;
        end
      end

      ST_TRAP: begin
        trap       = 1'b1;
        pc_next    = TRAP_PC;
        state_next = ST_FETCH;
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ibus.iadr_o  = pc_reg;
  assign ibus.istb_o  = istb;
  assign ir_o         = ir_reg;
  assign cstate_o     = cstate_out;
  assign pc_o         = pc_reg;
  assign trap_o       = trap;
  assign trap_cause_o = cause_reg;
  assign epc_o        = epc_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_0000;
  localparam logic [63:0] TRAP_PC  = 64'h0000_0000_0000_0100;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] ir_o;
  logic [2:0]  cstate_o;
  logic [2:0]  nstate_i;
  logic        defined_i;
  logic        pc_load_i;
  logic [63:0] pc_dat_i;
  logic [63:0] pc_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;
  logic [63:0] epc_o;

  fetch_sequencer_if ibus();

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .TRAP_PC  (TRAP_PC)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .ibus         (ibus),
    .ir_o         (ir_o),
    .cstate_o     (cstate_o),
    .nstate_i     (nstate_i),
    .defined_i    (defined_i),
    .pc_load_i    (pc_load_i),
    .pc_dat_i     (pc_dat_i),
    .pc_o         (pc_o),
    .trap_o       (trap_o),
    .trap_cause_o (trap_cause_o),
    .epc_o        (epc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  cause;
    logic [63:0] epc;
  } trap_t;

  // Scoreboard queues: filled when an instruction's stimulus is planned,
  // drained when the DUT shows the corresponding result.
  logic [31:0] ir_q[$];
  logic [63:0] pc_q[$];
  trap_t       trap_q[$];

  // Reference model state.
  logic [63:0] m_pc;
  logic [31:0] m_ir;
  logic [1:0]  m_cause;
  logic [63:0] m_epc;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_ir    = 32'h0000_0013;
    m_cause = 2'd0;
    m_epc   = 64'd0;
  endtask

  // One full instruction starting at a FETCH-cycle negedge.
  // bad_at: microcycle (0..2) at which the decoders return nstate 4..7, or -1.
  task automatic run_instr(input logic [31:0] word, input int ack_delay,
                           input logic def, input int bad_at,
                           input logic ld, input logic [63:0] dat);
    logic [31:0] e_ir;
    logic [63:0] e_pc;
    trap_t       e_trap;
    logic        trapped;
    logic        done;
    logic [1:0]  cause;
    logic [63:0] start_pc;

    start_pc = m_pc;
    trapped  = 1'b0;
    cause    = 2'd0;
    if (!def || (bad_at >= 0 && bad_at <= 2)) begin
      trapped = 1'b1;
      cause   = 2'd0;
    end else if (ld && dat[1:0] != 2'b00) begin
      trapped = 1'b1;
      cause   = 2'd1;
    end
    ir_q.push_back(word);
    if (trapped) begin
      trap_q.push_back({cause, m_pc});
      pc_q.push_back(TRAP_PC);
    end else begin
      pc_q.push_back(ld ? dat : m_pc + 64'd4);
    end

    ibus.iack_i = 1'b0;
    pc_load_i   = 1'b0;
    n_cmp++;
    if (ibus.istb_o !== 1'b1 || ibus.iadr_o !== m_pc) begin
      n_fail++;
      $display("FAIL fetch_entry: istb=%b iadr=%h, required istb=1 iadr=%h",
               ibus.istb_o, ibus.iadr_o, m_pc);
    end
    n_cmp++;
    if (trap_cause_o !== m_cause || epc_o !== m_epc) begin
      n_fail++;
      $display("FAIL trap_hold: cause=%0d epc=%h, required cause=%0d epc=%h",
               trap_cause_o, epc_o, m_cause, m_epc);
    end

    for (int i = 0; i < ack_delay; i++) begin
      ibus.idat_i = $urandom;
      step();
      n_cmp++;
      if (ibus.istb_o !== 1'b1 || ibus.iadr_o !== m_pc || ir_o !== m_ir || trap_o !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_wait[%0d]: istb=%b iadr=%h ir=%h trap=%b, required 1 %h %h 0",
                 i, ibus.istb_o, ibus.iadr_o, ir_o, trap_o, m_pc, m_ir);
      end
    end

    ibus.iack_i = 1'b1;
    ibus.idat_i = word;
    step();
    e_ir = ir_q.pop_front();
    n_cmp++;
    if (ir_o !== e_ir || cstate_o !== 3'd0 || ibus.istb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_ir: ir=%h cstate=%0d istb=%b, required ir=%h cstate=0 istb=0",
               ir_o, cstate_o, ibus.istb_o, e_ir);
    end
    m_ir = e_ir;

    done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (!done) begin
        // Acks outside FETCH must be ignored, so toggle them freely here.
        ibus.iack_i = 1'($urandom % 2);
        ibus.idat_i = $urandom;
        defined_i   = (c == 0) ? def : 1'($urandom % 2);
        nstate_i    = (c == bad_at) ? 3'(4 + $urandom % 4) : 3'(c + 1);
        step();
        if ((c == 0 && !def) || c == bad_at) begin
          done = 1'b1;
        end else begin
          n_cmp++;
          if (cstate_o !== 3'(c + 1) || ir_o !== m_ir) begin
            n_fail++;
            $display("FAIL exec_chain[%0d]: cstate=%0d ir=%h, required cstate=%0d ir=%h",
                     c, cstate_o, ir_o, c + 1, m_ir);
          end
        end
      end
    end

    if (!done) begin
      pc_load_i   = ld;
      pc_dat_i    = dat;
      nstate_i    = 3'($urandom);
      defined_i   = 1'($urandom % 2);
      ibus.iack_i = 1'($urandom % 2);
      step();
      pc_load_i   = 1'b0;
    end

    if (trapped) begin
      e_trap = trap_q.pop_front();
      n_cmp++;
      if (trap_o !== 1'b1 || trap_cause_o !== e_trap.cause || epc_o !== e_trap.epc ||
          ibus.istb_o !== 1'b0 || cstate_o !== 3'd7 || ir_o !== m_ir) begin
        n_fail++;
        $display("FAIL trap_pulse: trap=%b cause=%0d epc=%h istb=%b cstate=%0d ir=%h, required 1 %0d %h 0 7 %h",
                 trap_o, trap_cause_o, epc_o, ibus.istb_o, cstate_o, ir_o,
                 e_trap.cause, e_trap.epc, m_ir);
      end
      m_cause = e_trap.cause;
      m_epc   = e_trap.epc;
      ibus.iack_i = 1'($urandom % 2);
      step();
    end

    ibus.iack_i = 1'b0;
    e_pc = pc_q.pop_front();
    n_cmp++;
    if (pc_o !== e_pc || ibus.iadr_o !== e_pc || ibus.istb_o !== 1'b1 ||
        trap_o !== 1'b0 || cstate_o !== 3'd7 || ir_o !== m_ir) begin
      n_fail++;
      $display("FAIL next_fetch: pc=%h iadr=%h istb=%b trap=%b cstate=%0d ir=%h, required pc=%h istb=1 trap=0 cstate=7 ir=%h",
               pc_o, ibus.iadr_o, ibus.istb_o, trap_o, cstate_o, ir_o, e_pc, m_ir);
    end
    m_pc = e_pc;
    $display("instr pc=%h ir=%h wait=%0d trap=%b cause=%0d next_pc=%h",
             start_pc, word, ack_delay, trapped, cause, e_pc);
  endtask

  task automatic test_reset();
    reset_i     = 1'b1;
    ibus.iack_i = 1'b1;
    ibus.idat_i = 32'hDEAD_BEEF;
    defined_i   = 1'b0;
    nstate_i    = 3'd0;
    pc_load_i   = 1'b0;
    pc_dat_i    = 64'd0;
    step();
    step();
    model_reset();
    n_cmp++;
    if (pc_o !== RESET_PC || ibus.iadr_o !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_pc: pc=%h iadr=%h, required %h", pc_o, ibus.iadr_o, RESET_PC);
    end
    n_cmp++;
    if (ir_o !== 32'h0000_0013 || cstate_o !== 3'd7) begin
      n_fail++;
      $display("FAIL reset_ir: ir=%h cstate=%0d, required ir=00000013 cstate=7", ir_o, cstate_o);
    end
    n_cmp++;
    if (trap_o !== 1'b0 || trap_cause_o !== 2'd0 || epc_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_trap: trap=%b cause=%0d epc=%h, required 0 0 0",
               trap_o, trap_cause_o, epc_o);
    end
    ibus.iack_i = 1'b0;
    reset_i     = 1'b0;
    n_cmp++;
    if (ibus.istb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_istb: istb=%b, required 1", ibus.istb_o);
    end
    $display("reset done pc=%h ir=%h", pc_o, ir_o);
  endtask

  task automatic test_basic();
    run_instr(32'h0050_0093, 0, 1'b1, -1, 1'b0, 64'd0);
  endtask

  task automatic test_ack_delay();
    run_instr(32'h0010_8113, 3, 1'b1, -1, 1'b0, 64'd0);
  endtask

  task automatic test_illegal();
    run_instr(32'h0000_006F, 0, 1'b1, -1, 1'b1, 64'h40);
    run_instr(32'hFFFF_FFFF, 1, 1'b0, -1, 1'b0, 64'd0);
  endtask

  task automatic test_branch();
    run_instr(32'h2000_0067, 0, 1'b1, -1, 1'b1, 64'h200);
    run_instr(32'h2020_0067, 2, 1'b1, -1, 1'b1, 64'h202);
  endtask

  task automatic test_bad_nstate();
    run_instr(32'h1234_5678, 0, 1'b1, 1, 1'b0, 64'd0);
    run_instr(32'h8765_4321, 0, 1'b1, 0, 1'b0, 64'd0);
    run_instr(32'h0BAD_0BAD, 0, 1'b1, 2, 1'b1, 64'h300);
  endtask

  task automatic test_wrap();
    run_instr(32'h0000_0067, 0, 1'b1, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(32'h0000_0013, 0, 1'b1, -1, 1'b0, 64'd0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      logic [63:0] tgt;
      tgt = {32'($urandom), 32'($urandom)} & ~64'h3;
      run_instr($urandom, int'($urandom_range(0, 2)), 1'b1, -1, 1'($urandom % 2), tgt);
    end
  endtask

  task automatic test_timeout();
    trap_t e_trap;
    // An ack on the final allowed cycle must still be taken.
    run_instr(32'h00C0_0093, 255, 1'b1, -1, 1'b0, 64'd0);
`ifdef FETCH_TIMEOUT_EN
    ibus.iack_i = 1'b0;
    for (int i = 0; i < 255; i++) step();
    n_cmp++;
    if (trap_o !== 1'b0 || ibus.istb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: trap=%b istb=%b after 255 cycles, required trap=0 istb=1",
               trap_o, ibus.istb_o);
    end
    trap_q.push_back({2'd2, m_pc});
    step();
    e_trap = trap_q.pop_front();
    n_cmp++;
    if (trap_o !== 1'b1 || trap_cause_o !== e_trap.cause || epc_o !== e_trap.epc) begin
      n_fail++;
      $display("FAIL timeout_trap: trap=%b cause=%0d epc=%h, required 1 %0d %h",
               trap_o, trap_cause_o, epc_o, e_trap.cause, e_trap.epc);
    end
    m_cause = e_trap.cause;
    m_epc   = e_trap.epc;
    step();
    n_cmp++;
    if (pc_o !== TRAP_PC || trap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_redirect: pc=%h trap=%b, required %h 0", pc_o, trap_o, TRAP_PC);
    end
    m_pc = TRAP_PC;
    $display("timeout trap epc=%h", e_trap.epc);
`else
    // Without the timeout, a long stall simply waits for the ack.
    run_instr(32'h0020_0093, 300, 1'b1, -1, 1'b0, 64'd0);
`endif
  endtask

  task automatic test_reset_mid_exec();
    ibus.iack_i = 1'b1;
    ibus.idat_i = 32'h0AAA_0AAA;
    defined_i   = 1'b1;
    nstate_i    = 3'd1;
    step();
    ibus.iack_i = 1'b0;
    nstate_i    = 3'd2;
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    model_reset();
    n_cmp++;
    if (pc_o !== RESET_PC || cstate_o !== 3'd7 || ir_o !== 32'h0000_0013 || ibus.istb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_exec: pc=%h cstate=%0d ir=%h istb=%b, required %h 7 00000013 1",
               pc_o, cstate_o, ir_o, ibus.istb_o, RESET_PC);
    end
    n_cmp++;
    if (trap_cause_o !== 2'd0 || epc_o !== 64'd0 || trap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_exec_trap: cause=%0d epc=%h trap=%b, required 0 0 0",
               trap_cause_o, epc_o, trap_o);
    end
    $display("reset mid-exec pc=%h", pc_o);
    run_instr(32'h0050_0093, 0, 1'b1, -1, 1'b0, 64'd0);
  endtask

  initial begin
    reset_i     = 1'b1;
    ibus.iack_i = 1'b0;
    ibus.idat_i = 32'd0;
    defined_i   = 1'b0;
    nstate_i    = 3'd0;
    pc_load_i   = 1'b0;
    pc_dat_i    = 64'd0;
    model_reset();
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_ack_delay();
    test_illegal();
    test_branch();
    test_bad_nstate();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL provide parameter RESET_PC, default 64'h0000_0000_0000_0000, PC loaded by reset.
REQ-002 SHALL provide parameter TRAP_PC, default 64'h0000_0000_0000_0100, PC loaded on any trap.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 iadr_o  output  64  instruction fetch address, equal to pc_o.
REQ-006 istb_o  output  1  fetch request strobe.
REQ-007 iack_i  input  1  fetch acknowledge; idat_i is valid in the same cycle.
REQ-008 idat_i  input  32  fetched instruction word.
REQ-009 ir_o  output  32  instruction register, feeding the decoder ir_i inputs.
REQ-010 cstate_o  output  3  microcycle state, feeding the decoder cstate_i inputs.
REQ-011 nstate_i  input  3  next microcycle state from the decoders (OR of all decoder nstate outputs).
REQ-012 defined_i  input  1  OR of all decoder defined outputs.
REQ-013 pc_load_i  input  1  on completion, load PC from pc_dat_i instead of incrementing it.
REQ-014 pc_dat_i  input  64  branch or jump target.
REQ-015 pc_o  output  64  current instruction address.
REQ-016 trap_o  output  1  one-cycle trap pulse.
REQ-017 trap_cause_o  output  2  trap cause: 0 = illegal instruction, 1 = misaligned target, 2 = fetch timeout.
REQ-018 epc_o  output  64  PC of the instruction that trapped.

Function
REQ-019 SHALL implement exactly three states: FETCH, EXEC and TRAP.
REQ-020 FETCH: istb_o=1 and cstate_o=3'd7, so that no decoder s0/s1/s2 term is active.
REQ-021 FETCH with iack_i=1 at the edge: ir_o<=idat_i, cstate_o<=0, go to EXEC; otherwise stay in FETCH with istb_o held at 1.
REQ-022 iack_i SHALL be ignored outside FETCH.
REQ-023 EXEC with cstate_o==0 and defined_i==0: go to TRAP with cause 0 and epc<=pc; ir_o is unchanged.
REQ-024 EXEC with cstate_o in 0..2 (and defined when cstate_o==0): cstate_o<=nstate_i.
REQ-025 EXEC with cstate_o==3 marks instruction completion; it is sampled in that cycle:
- pc_load_i=0: pc<=pc+4 (64-bit, wraps modulo 2^64), go to FETCH.
- pc_load_i=1 and pc_dat_i[1:0]==0: pc<=pc_dat_i, go to FETCH.
- pc_load_i=1 and pc_dat_i[1:0]!=0: go to TRAP with cause 1 and epc<=pc.
REQ-026 EXEC with nstate_i in 4..7 while cstate_o<3: treat as cause 0 and go to TRAP.
REQ-027 TRAP: trap_o=1 for exactly one cycle, istb_o=0, cstate_o=3'd7, pc<=TRAP_PC, then go to FETCH.
REQ-028 trap_cause_o and epc_o SHALL hold their values until the next trap.
REQ-029 Minimum instruction latency: 1 fetch cycle + 4 EXEC cycles (states 0..3) = 5 cycles with zero-wait acknowledge.

Reset
REQ-030 reset_i=1 at an edge SHALL, from any state including mid-fetch, force:
- FETCH, pc_o=RESET_PC, ir_o=32'h0000_0013, cstate_o=3'd7;
- trap_o=0, trap_cause_o=0, epc_o=0, and the timeout counter cleared.
REQ-031 istb_o SHALL be 1 in the first cycle after reset is released.
REQ-032 An iack_i coincident with reset_i SHALL be discarded.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to FETCH and increments each FETCH cycle without iack_i; when it reaches 255 without ack, go to TRAP with cause 2 and epc<=pc. An ack in the same cycle as count 255 wins.
- Undefined: no counter is built, FETCH waits indefinitely, and cause 2 is never produced.

Verification
REQ-034 Reset release, idat_i=32'h0050_0093 acked in 1 cycle, decoder chain 0->1->2->3 -> ir_o=32'h0050_0093, then pc_o=4 and istb_o=1 five cycles after the first strobe.
REQ-035 Fetch with iack_i delayed 3 cycles -> istb_o held at 1 with iadr_o stable for 3 cycles, and ir_o updated only on the ack edge.
REQ-036 defined_i=0 at cstate_o=0 with pc=64'h40 -> trap_o pulses one cycle, trap_cause_o=0, epc_o=64'h40, next iadr_o=64'h100.
REQ-037 Completion with pc_load_i=1: pc_dat_i=64'h200 -> pc_o=64'h200; pc_dat_i=64'h202 -> trap with cause 1.
REQ-038 pc=64'hFFFF_FFFF_FFFF_FFFC completing with pc_load_i=0 -> pc_o=0.
REQ-039 With FETCH_TIMEOUT_EN defined and no ack -> trap cause 2 after 256 FETCH cycles; reset asserted mid-EXEC -> pc_o=RESET_PC and cstate_o=7 on the next cycle.
